// File: rtl/prim_clk_div_pkg.sv
// Shared state encodings for the multi-channel clock-enable divider.
package prim_clk_div_pkg;

    // Per-channel FSM encoding.
    typedef logic [1:0] ch_state_e;
    localparam ch_state_e CH_IDLE  = 2'd0;
    localparam ch_state_e CH_RUN   = 2'd1;
    localparam ch_state_e CH_DRAIN = 2'd2;

    // Ratio-update handshake FSM encoding.
    typedef logic [0:0] cfg_state_e;
    localparam cfg_state_e CFG_IDLE = 1'b0;
    localparam cfg_state_e CFG_PEND = 1'b1;

endpackage

// File: rtl/prim_clk_div_ch.sv
// One divider channel: run/drain FSM, period counter, active ratio and outputs.
// A staged ratio is adopted only when idle or on the last cycle of a period.
module prim_clk_div_ch
    import prim_clk_div_pkg::*;
#(
    parameter int unsigned DivW     = 4,
    parameter int unsigned ResetDiv = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            test_en_i,
    input  logic            ch_en_i,
    input  logic            pend_i,
    input  logic [DivW-1:0] staged_i,
    output logic            loaded_o,
    output logic            active_o,
    output logic            stb_o,
    output logic            clk_div_o
);

    ch_state_e       state_q, state_d;
    logic [DivW-1:0] cnt_q, cnt_d;
    logic [DivW-1:0] div_q, div_d;
    logic            clk_div_q, clk_div_d;
    logic            last;
    logic [DivW:0]   half;

    // Next-state for FSM, counter, ratio and registered divided-clock level.
    always_comb begin
        last     = (cnt_q == div_q);
        loaded_o = pend_i && ((state_q == CH_IDLE) || last);
        div_d    = loaded_o ? staged_i : div_q;
        state_d  = state_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            CH_IDLE: begin
                cnt_d = '0;
                if (ch_en_i) state_d = CH_RUN;
            end
            CH_RUN: begin
                if (last) begin
                    cnt_d = '0;
                    if (!ch_en_i) state_d = CH_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!ch_en_i) state_d = CH_DRAIN;
                end
            end
            CH_DRAIN: begin
                // Finish the current period; re-enable resumes without restarting it.
                if (last) begin
                    cnt_d   = '0;
                    state_d = ch_en_i ? CH_RUN : CH_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (ch_en_i) state_d = CH_RUN;
                end
            end
            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
            end
        endcase

        // High phase is ceil(R/2) cycles, computed one bit wider to cover R = 2^DivW.
        half      = ({1'b0, div_d} + (DivW+1)'(2)) >> 1;
        clk_div_d = (state_d != CH_IDLE) && ({1'b0, cnt_d} < half);
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            div_q     <= DivW'(ResetDiv);
            clk_div_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            clk_div_q <= clk_div_d;
        end
    end

    assign active_o  = (state_q != CH_IDLE);
    assign stb_o     = ((state_q == CH_RUN) && (cnt_q == '0)) || test_en_i;
    assign clk_div_o = clk_div_q;

endmodule

// File: rtl/prim_multi_clk_div_gen.sv
// Multi-channel clock-enable generator: NumCh divider channels plus the
// shared ratio-update handshake (staged values, per-channel pending mask).
module prim_multi_clk_div_gen
    import prim_clk_div_pkg::*;
#(
    parameter int unsigned NumCh    = 4,
    parameter int unsigned DivW     = 4,
    parameter int unsigned ResetDiv = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  test_en_i,
    input  logic [NumCh-1:0]      ch_en_i,
    input  logic [NumCh*DivW-1:0] div_i,
    input  logic                  cfg_req_i,
    output logic                  cfg_busy_o,
    output logic                  cfg_ack_o,
    output logic [NumCh-1:0]      ch_active_o,
    output logic [NumCh-1:0]      stb_o,
    output logic [NumCh-1:0]      clk_div_o
);

    cfg_state_e                   cfg_state_q, cfg_state_d;
    logic [NumCh-1:0][DivW-1:0]   staged_q, staged_d;
    logic [NumCh-1:0]             pend_q, pend_d;
    logic [NumCh-1:0]             loaded;
    logic                         cfg_ack_q, cfg_ack_d;

    // Config handshake: capture in idle, retire pending channels as they load.
    always_comb begin
        cfg_state_d = cfg_state_q;
        staged_d    = staged_q;
        pend_d      = pend_q & ~loaded;
        cfg_ack_d   = 1'b0;

        unique case (cfg_state_q)
            CFG_IDLE: begin
                if (cfg_req_i) begin
                    staged_d    = div_i;
                    pend_d      = '1;
                    cfg_state_d = CFG_PEND;
                end
            end
            CFG_PEND: begin
                // Requests are ignored here; ack lands in idle so a new request can follow.
                if (pend_d == '0) begin
                    cfg_state_d = CFG_IDLE;
                    cfg_ack_d   = 1'b1;
                end
            end
            default: begin
                cfg_state_d = CFG_IDLE;
                pend_d      = '0;
            end
        endcase
    end

    // Config registers with synchronous reset; reset drops any pending update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_state_q <= CFG_IDLE;
            staged_q    <= {NumCh{DivW'(ResetDiv)}};
            pend_q      <= '0;
            cfg_ack_q   <= 1'b0;
        end else begin
            cfg_state_q <= cfg_state_d;
            staged_q    <= staged_d;
            pend_q      <= pend_d;
            cfg_ack_q   <= cfg_ack_d;
        end
    end

    assign cfg_busy_o = (cfg_state_q == CFG_PEND);
    assign cfg_ack_o  = cfg_ack_q;

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        prim_clk_div_ch #(
            .DivW     (DivW),
            .ResetDiv (ResetDiv)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .test_en_i (test_en_i),
            .ch_en_i   (ch_en_i[c]),
            .pend_i    (pend_q[c]),
            .staged_i  (staged_q[c]),
            .loaded_o  (loaded[c]),
            .active_o  (ch_active_o[c]),
            .stb_o     (stb_o[c]),
            .clk_div_o (clk_div_o[c])
        );
    end

endmodule

// File: tb/tb_prim_multi_clk_div_gen.sv
// Directed bench for prim_multi_clk_div_gen: a per-cycle vector table for the
// run/drain behaviour plus hand-written ratio-update and reset sequences.
module tb_prim_multi_clk_div_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        test_en;
    logic [3:0]  ch_en;
    logic [15:0] div;
    logic        cfg_req;
    logic        busy, ack;
    logic [3:0]  act, stb, clk_div;

    int checks = 0;
    int errors = 0;
    int acks   = 0;
    int a0;

    typedef struct packed {
        logic [3:0] ch_en;
        logic       test_en;
        logic [3:0] stb;
        logic [3:0] clk_div;
        logic [3:0] act;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    prim_multi_clk_div_gen #(
        .NumCh    (4),
        .DivW     (4),
        .ResetDiv (0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .test_en_i   (test_en),
        .ch_en_i     (ch_en),
        .div_i       (div),
        .cfg_req_i   (cfg_req),
        .cfg_busy_o  (busy),
        .cfg_ack_o   (ack),
        .ch_active_o (act),
        .stb_o       (stb),
        .clk_div_o   (clk_div)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (ack) acks++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        // {ch_en, test_en, stb, clk_div, active}; ch1 at R=5, ch0 dropped on entry 0.
        vecs[0]  = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0010};
        vecs[1]  = '{4'b0010, 1'b0, 4'b0000, 4'b0010, 4'b0010};
        vecs[2]  = '{4'b0010, 1'b0, 4'b0000, 4'b0010, 4'b0010};
        vecs[3]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0010};
        vecs[4]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0010};
        vecs[5]  = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0010};
        vecs[6]  = '{4'b0010, 1'b0, 4'b0000, 4'b0010, 4'b0010};
        vecs[7]  = '{4'b0010, 1'b0, 4'b0000, 4'b0010, 4'b0010};
        vecs[8]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0010};
        vecs[9]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0010};
        vecs[10] = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0010};
        vecs[11] = '{4'b0010, 1'b0, 4'b0000, 4'b0010, 4'b0010};
        // drop at cnt=1: drain cnt 2,3,4 then idle
        vecs[12] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0010};
        vecs[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        // test bypass while idle
        vecs[16] = '{4'b0000, 1'b1, 4'b1111, 4'b0000, 4'b0000};
        vecs[17] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        // bypass during a run start does not touch clk_div
        vecs[18] = '{4'b0010, 1'b1, 4'b1111, 4'b0010, 4'b0010};
        // drain at cnt1, re-enable at cnt2 resumes the same period
        vecs[19] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0010};
        vecs[20] = '{4'b0010, 1'b0, 4'b0000, 4'b0010, 4'b0010};
        vecs[21] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0010};
        vecs[22] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0010};
        vecs[23] = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0010};
        vecs[24] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0010};
        vecs[25] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0010};
        vecs[26] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010};
        vecs[27] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010};
        vecs[28] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};

        rst = 1'b1; test_en = 1'b0; ch_en = '0; div = '0; cfg_req = 1'b0;
        tick(); tick();
        check("reset_outputs", 32'({stb, clk_div, act, busy, ack}), 32'h0);
        rst = 1'b0;
        tick(); tick(); tick();

        // R=1 on ch0: strobe every cycle, level stays high
        ch_en = 4'b0001;
        tick();
        check("r1_stb_first", 32'(stb), 32'h1);
        check("r1_clk_div", 32'(clk_div), 32'h1);
        check("r1_active", 32'(act), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r1_stb_each", 32'(stb), 32'h1);
        end

        // load R=5 onto ch1
        div = 16'h0040; cfg_req = 1'b1;
        tick();
        check("cfg1_busy", 32'(busy), 32'h1);
        cfg_req = 1'b0;
        tick();
        check("cfg1_ack", 32'(ack), 32'h1);
        check("cfg1_busy_clr", 32'(busy), 32'h0);
        tick();
        check("cfg1_ack_pulse", 32'(ack), 32'h0);

        for (int i = 0; i < NV; i++) begin
            ch_en   = vecs[i].ch_en;
            test_en = vecs[i].test_en;
            tick();
            if (stb !== vecs[i].stb || clk_div !== vecs[i].clk_div || act !== vecs[i].act) begin
                errors++;
                $display("FAIL vec%0d: got stb=%b clk_div=%b act=%b expected stb=%b clk_div=%b act=%b",
                         i, stb, clk_div, act, vecs[i].stb, vecs[i].clk_div, vecs[i].act);
            end
            checks++;
        end
        test_en = 1'b0;

        // ch0 at R=3, then update all to R=2 while ch0 mid-period and ch2 idle
        div = 16'h0002; cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        tick();
        check("cfg2_ack", 32'(ack), 32'h1);
        tick();
        ch_en = 4'b0001;
        tick();
        check("r3_stb_cnt0", 32'(stb), 32'h1);
        check("r3_clk_cnt0", 32'(clk_div), 32'h1);
        a0 = acks;
        div = 16'h1111; cfg_req = 1'b1;
        tick();
        check("upd_busy", 32'(busy), 32'h1);
        check("upd_clk_cnt1", 32'({stb, clk_div}), 32'h01);
        div = 16'h7777;
        tick();
        check("upd_busy_hold", 32'({busy, ack}), 32'h2);
        check("upd_clk_cnt2", 32'(clk_div), 32'h0);
        cfg_req = 1'b0; div = '0;
        tick();
        check("upd_ack", 32'({busy, ack}), 32'h1);
        check("upd_new_period_stb", 32'(stb), 32'h1);
        tick();
        check("r2_cnt1", 32'({stb, clk_div}), 32'h00);
        tick();
        check("r2_cnt0", 32'({stb, clk_div}), 32'h11);
        check("upd_single_ack", 32'(acks - a0), 32'd1);
        ch_en = 4'b0101;
        tick();
        check("ch2_r2_start", 32'({stb, clk_div}), 32'h44);
        tick();
        check("ch2_r2_second", 32'({stb, clk_div}), 32'h11);

        // reset while ch0 drains with an update pending
        ch_en = 4'b0100; div = 16'h3333; cfg_req = 1'b1;
        tick();
        check("pre_rst_active", 32'(act), 32'h5);
        check("pre_rst_busy", 32'(busy), 32'h1);
        check("pre_rst_stb", 32'(stb), 32'h4);
        cfg_req = 1'b0;
        a0 = acks;
        rst = 1'b1;
        tick();
        check("mid_rst_outputs", 32'({stb, clk_div, act, busy, ack}), 32'h0);
        rst = 1'b0; ch_en = '0;
        tick(); tick(); tick();
        check("post_rst_no_ack", 32'(acks - a0), 32'd0);
        check("post_rst_busy", 32'(busy), 32'h0);
        ch_en = 4'b0001;
        tick();
        check("post_rst_r1_a", 32'(stb), 32'h1);
        tick();
        check("post_rst_r1_b", 32'(stb), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
